// File: rtl/alu_mp_seq.sv
// Multi-precision ALU sequencer: streams W-bit operands one slice per
// cycle through an external combinational DATA_WIDTH-bit ALU.
module alu_mp_seq #(
  parameter int DATA_WIDTH   = 8,
  parameter int OPCODE_WIDTH = 3,
  parameter int WORDS        = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [OPCODE_WIDTH-1:0]       req_op,
  input  logic [DATA_WIDTH*WORDS-1:0]   req_a,
  input  logic [DATA_WIDTH*WORDS-1:0]   req_b,
  input  logic                          req_cin,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [DATA_WIDTH*WORDS-1:0]   rsp_data,
  output logic                          rsp_carry,
  output logic [DATA_WIDTH-1:0]         alu_i_1,
  output logic [DATA_WIDTH-1:0]         alu_i_2,
  output logic [OPCODE_WIDTH-1:0]       alu_op_code,
  output logic                          alu_carry_in,
  input  logic [DATA_WIDTH-1:0]         alu_o_main,
  input  logic                          alu_carry_out
);

  localparam int W  = DATA_WIDTH * WORDS;
  localparam int KW = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef logic [OPCODE_WIDTH-1:0] op_t;

  localparam op_t OP_ADD  = op_t'(0);
  localparam op_t OP_ADDF = op_t'(1);
  localparam op_t OP_SUB  = op_t'(2);
  localparam op_t OP_AND  = op_t'(3);
  localparam op_t OP_OR   = op_t'(4);
  localparam op_t OP_XOR  = op_t'(5);
  localparam op_t OP_NOT  = op_t'(6);
  localparam op_t OP_LOAD = op_t'(7);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    DONE
  } state_t;

  state_t          state;
  logic [KW-1:0]   k;
  op_t             op_q;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;
  logic            cin_q;
  logic            carry_q;

  logic [DATA_WIDTH-1:0] a_sl;
  logic [DATA_WIDTH-1:0] b_sl;
  logic                  first;
  logic                  last;
  logic                  is_arith;

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == DONE);
  assign first     = (k == '0);
  assign last      = (k == KW'(WORDS - 1));
  assign is_arith  = (op_q == OP_ADD) || (op_q == OP_ADDF)
                  || (op_q == OP_SUB);

  always_comb begin
    a_sl = '0;
    b_sl = '0;
    for (int i = 0; i < WORDS; i++) begin
      if (k == KW'(i)) begin
        a_sl = a_q[i*DATA_WIDTH +: DATA_WIDTH];
        b_sl = b_q[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Arithmetic slices chain through ADDF; slice 0 seeds the carry.
  always_comb begin
    alu_i_1      = '0;
    alu_i_2      = '0;
    alu_op_code  = '0;
    alu_carry_in = 1'b0;
    if (state == EXEC) begin
      alu_i_1 = a_sl;
      alu_i_2 = b_sl;
      unique case (op_q)
        OP_ADD: begin
          alu_op_code  = first ? OP_ADD : OP_ADDF;
          alu_carry_in = first ? 1'b0 : carry_q;
        end
        OP_ADDF: begin
          alu_op_code  = OP_ADDF;
          alu_carry_in = first ? cin_q : carry_q;
        end
        OP_SUB: begin
          alu_op_code  = OP_ADDF;
          alu_i_2      = ~b_sl;
          alu_carry_in = first ? 1'b1 : carry_q;
        end
        OP_AND, OP_OR, OP_XOR, OP_NOT: begin
          alu_op_code = op_q;
        end
        default: begin
          alu_op_code = OP_LOAD;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      k         <= '0;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      cin_q     <= 1'b0;
      carry_q   <= 1'b0;
      rsp_data  <= '0;
      rsp_carry <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            op_q    <= req_op;
            a_q     <= req_a;
            b_q     <= req_b;
            cin_q   <= req_cin;
            k       <= '0;
            carry_q <= 1'b0;
            state   <= EXEC;
          end
        end
        EXEC: begin
          for (int i = 0; i < WORDS; i++) begin
            if (k == KW'(i)) begin
              rsp_data[i*DATA_WIDTH +: DATA_WIDTH] <= alu_o_main;
            end
          end
          carry_q <= alu_carry_out;
          if (last) begin
            rsp_carry <= is_arith & alu_carry_out;
            state     <= DONE;
          end else begin
            k <= k + KW'(1);
          end
        end
        DONE: begin
          if (rsp_ready) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mp_seq.sv
// Self-checking bench for alu_mp_seq with a behavioural slice ALU
// and a whole-word arithmetic reference model.
module tb_alu_mp_seq;

  localparam int DW = 8;
  localparam int OW = 3;
  localparam int WD = 4;
  localparam int W  = DW * WD;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic [OW-1:0] req_op;
  logic [W-1:0]  req_a;
  logic [W-1:0]  req_b;
  logic          req_cin;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [W-1:0]  rsp_data;
  logic          rsp_carry;
  logic [DW-1:0] alu_i_1;
  logic [DW-1:0] alu_i_2;
  logic [OW-1:0] alu_op_code;
  logic          alu_carry_in;
  logic [DW-1:0] alu_o_main;
  logic          alu_carry_out;
  logic [DW:0]   alu_s;

  int n_checks = 0;
  int n_pass   = 0;
  int lat;
  logic [OW-1:0] opseq [WD];
  logic          cinseq [WD];

  always #5 clk = ~clk;

  alu_mp_seq #(
    .DATA_WIDTH  (DW),
    .OPCODE_WIDTH(OW),
    .WORDS       (WD)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_op       (req_op),
    .req_a        (req_a),
    .req_b        (req_b),
    .req_cin      (req_cin),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_data     (rsp_data),
    .rsp_carry    (rsp_carry),
    .alu_i_1      (alu_i_1),
    .alu_i_2      (alu_i_2),
    .alu_op_code  (alu_op_code),
    .alu_carry_in (alu_carry_in),
    .alu_o_main   (alu_o_main),
    .alu_carry_out(alu_carry_out)
  );

  always_comb begin
    alu_s = '0;
    case (alu_op_code)
      3'd0: alu_s = {1'b0, alu_i_1} + {1'b0, alu_i_2};
      3'd1: alu_s = {1'b0, alu_i_1} + {1'b0, alu_i_2}
                  + {{DW{1'b0}}, alu_carry_in};
      3'd2: alu_s = {1'b0, alu_i_1} - {1'b0, alu_i_2};
      3'd3: alu_s = {1'b0, alu_i_1 & alu_i_2};
      3'd4: alu_s = {1'b0, alu_i_1 | alu_i_2};
      3'd5: alu_s = {1'b0, alu_i_1 ^ alu_i_2};
      3'd6: alu_s = {1'b0, ~alu_i_1};
      default: alu_s = {1'b0, alu_i_2};
    endcase
    alu_o_main    = alu_s[DW-1:0];
    alu_carry_out = alu_s[DW];
  end

  function automatic void model(input logic [OW-1:0] op,
                                input logic [W-1:0] a,
                                input logic [W-1:0] b,
                                input logic cin,
                                output logic [W-1:0] d,
                                output logic c);
    logic [W:0] s;
    s = '0;
    c = 1'b0;
    case (op)
      3'd0: begin s = {1'b0, a} + {1'b0, b}; c = s[W]; end
      3'd1: begin s = {1'b0, a} + {1'b0, b} + (W+1)'(cin); c = s[W]; end
      3'd2: begin s = {1'b0, a - b}; c = (a >= b); end
      3'd3: s = {1'b0, a & b};
      3'd4: s = {1'b0, a | b};
      3'd5: s = {1'b0, a ^ b};
      3'd6: s = {1'b0, ~a};
      default: s = {1'b0, b};
    endcase
    d = s[W-1:0];
  endfunction

  task automatic issue(input logic [OW-1:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic cin);
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    req_cin   = cin;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_op    = OW'($urandom);
    req_a     = $urandom;
    req_b     = $urandom;
    req_cin   = ~cin;
    @(negedge clk);
  endtask

  task automatic wait_rsp();
    lat = -1;
    for (int i = 0; i < 20; i++) begin
      if (i < WD) begin
        opseq[i]  = alu_op_code;
        cinseq[i] = alu_carry_in;
      end
      if (rsp_valid) begin
        lat = i;
        break;
      end
      @(negedge clk);
    end
    if (lat < 0) begin
      n_checks++;
      $display("FAIL rsp_timeout: rsp_valid=%0b after 20 cycles, want 1",
               rsp_valid);
    end
  endtask

  task automatic consume();
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    req_cin   = 1'b0;
    rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({req_ready, rsp_valid} !== 2'b10)
      $display("FAIL reset_hs: ready/valid=%b want 10",
               {req_ready, rsp_valid});
    else n_pass++;
    n_checks++;
    if ({rsp_data, rsp_carry} !== '0)
      $display("FAIL reset_rsp: data=%h carry=%b want 0",
               rsp_data, rsp_carry);
    else n_pass++;
    n_checks++;
    if ({alu_i_1, alu_i_2, alu_op_code, alu_carry_in} !== '0)
      $display("FAIL reset_alu: i1=%h i2=%h op=%0d cin=%b want 0",
               alu_i_1, alu_i_2, alu_op_code, alu_carry_in);
    else n_pass++;
  endtask

  task automatic test_add_seq();
    issue(3'd0, 32'h00FFFFFF, 32'h00000001, 1'b1);
    wait_rsp();
    n_checks++;
    if (rsp_data !== 32'h01000000)
      $display("FAIL add_seq_data: got %h want 01000000", rsp_data);
    else n_pass++;
    n_checks++;
    if (rsp_carry !== 1'b0)
      $display("FAIL add_seq_carry: got %b want 0", rsp_carry);
    else n_pass++;
    n_checks++;
    if (lat !== 4)
      $display("FAIL add_seq_latency: got %0d want 4", lat);
    else n_pass++;
    n_checks++;
    if ({opseq[0], opseq[1], opseq[2], opseq[3]} !== 12'o0111)
      $display("FAIL add_seq_ops: got %0d %0d %0d %0d want 0 1 1 1",
               opseq[0], opseq[1], opseq[2], opseq[3]);
    else n_pass++;
    n_checks++;
    if (cinseq[0] !== 1'b0)
      $display("FAIL add_seq_cin0: got %b want 0", cinseq[0]);
    else n_pass++;
    consume();
    n_checks++;
    if ({req_ready, rsp_valid, alu_op_code, alu_i_1, alu_i_2} !==
        {2'b10, {(OW+2*DW){1'b0}}})
      $display("FAIL add_seq_idle: ready=%b valid=%b op=%0d i1=%h i2=%h want 1 0 0 0 0",
               req_ready, rsp_valid, alu_op_code, alu_i_1, alu_i_2);
    else n_pass++;
  endtask

  task automatic test_vectors();
    logic [OW-1:0] ops [7] = '{3'd0, 3'd1, 3'd2, 3'd2, 3'd5, 3'd6, 3'd7};
    logic [W-1:0] va [7] = '{32'hFFFFFFFF, 32'h0, 32'h100, 32'h0,
                            32'hF0F0F0F0, 32'h12345678, 32'h5A5A5A5A};
    logic [W-1:0] vb [7] = '{32'h1, 32'h0, 32'h1, 32'h1,
                            32'hFFFF0000, 32'hFFFFFFFF, 32'hCAFEBABE};
    logic vc [7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [W-1:0] ed [7] = '{32'h0, 32'h1, 32'hFF, 32'hFFFFFFFF,
                            32'h0F0FF0F0, 32'hEDCBA987, 32'hCAFEBABE};
    logic ec [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 7; i++) begin
      issue(ops[i], va[i], vb[i], vc[i]);
      wait_rsp();
      n_checks++;
      if ({rsp_data, rsp_carry} !== {ed[i], ec[i]})
        $display("FAIL vector_%0d: data=%h carry=%b want data=%h carry=%b",
                 i, rsp_data, rsp_carry, ed[i], ec[i]);
      else n_pass++;
      if (ops[i] == 3'd2) begin
        n_checks++;
        if ({opseq[0], opseq[3], cinseq[0]} !== {3'd1, 3'd1, 1'b1})
          $display("FAIL vector_%0d_sub_issue: op0=%0d op3=%0d cin0=%b want 1 1 1",
                   i, opseq[0], opseq[3], cinseq[0]);
        else n_pass++;
      end
      consume();
    end
  endtask

  task automatic test_random();
    logic [OW-1:0] op;
    logic [W-1:0]  a, b, ed;
    logic          cin, ec;
    for (int i = 0; i < 40; i++) begin
      op  = OW'($urandom_range(0, 7));
      a   = $urandom;
      b   = (i % 5 == 0) ? a : $urandom;
      cin = 1'($urandom_range(0, 1));
      model(op, a, b, cin, ed, ec);
      issue(op, a, b, cin);
      wait_rsp();
      n_checks++;
      if ({rsp_data, rsp_carry, lat} !== {ed, ec, 4})
        $display("FAIL random_%0d op=%0d a=%h b=%h cin=%b: data=%h carry=%b lat=%0d want %h %b 4",
                 i, op, a, b, cin, rsp_data, rsp_carry, lat, ed, ec);
      else n_pass++;
      consume();
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] a, b, hd, ed, x, y;
    logic         hc, ec;
    a = $urandom;
    b = $urandom;
    x = $urandom;
    y = $urandom;
    model(3'd0, a, b, 1'b0, ed, ec);
    issue(3'd0, a, b, 1'b0);
    wait_rsp();
    hd = rsp_data;
    hc = rsp_carry;
    n_checks++;
    if ({hd, hc} !== {ed, ec})
      $display("FAIL hold_first: data=%h carry=%b want %h %b",
               hd, hc, ed, ec);
    else n_pass++;
    req_valid = 1'b1;
    req_op    = 3'd5;
    req_a     = x;
    req_b     = y;
    req_cin   = 1'b0;
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      n_checks++;
      if ({rsp_valid, req_ready, rsp_data, rsp_carry} !==
          {2'b10, ed, ec})
        $display("FAIL hold_cycle_%0d: valid=%b ready=%b data=%h carry=%b want 1 0 %h %b",
                 j, rsp_valid, req_ready, rsp_data, rsp_carry, ed, ec);
      else n_pass++;
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({req_ready, rsp_valid} !== 2'b10)
      $display("FAIL hold_release: ready=%b valid=%b want 1 0",
               req_ready, rsp_valid);
    else n_pass++;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_a     = $urandom;
    req_b     = $urandom;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 1'b0)
      $display("FAIL hold_second_accept: ready=%b want 0", req_ready);
    else n_pass++;
    wait_rsp();
    n_checks++;
    if ({rsp_data, rsp_carry, lat} !== {x ^ y, 1'b0, 4})
      $display("FAIL hold_second: data=%h carry=%b lat=%0d want %h 0 4",
               rsp_data, rsp_carry, lat, x ^ y);
    else n_pass++;
    consume();
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] a, b, ed;
    logic         ec;
    int           seen;
    issue(3'd0, 32'h11111111, 32'h22222222, 1'b0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({alu_i_1, alu_i_2, alu_op_code, alu_carry_in} !== '0)
      $display("FAIL rst_mid_alu: i1=%h i2=%h op=%0d cin=%b want 0",
               alu_i_1, alu_i_2, alu_op_code, alu_carry_in);
    else n_pass++;
    n_checks++;
    if ({rsp_valid, rsp_data, rsp_carry} !== '0)
      $display("FAIL rst_mid_rsp: valid=%b data=%h carry=%b want 0",
               rsp_valid, rsp_data, rsp_carry);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      if (rsp_valid || !req_ready) seen++;
    end
    n_checks++;
    if (seen !== 0)
      $display("FAIL rst_mid_abort: %0d cycles not idle, want 0", seen);
    else n_pass++;
    a = $urandom;
    b = $urandom;
    model(3'd0, a, b, 1'b0, ed, ec);
    issue(3'd0, a, b, 1'b0);
    wait_rsp();
    n_checks++;
    if ({rsp_data, rsp_carry, lat} !== {ed, ec, 4})
      $display("FAIL rst_mid_next: data=%h carry=%b lat=%0d want %h %b 4",
               rsp_data, rsp_carry, lat, ed, ec);
    else n_pass++;
    consume();
  endtask

  initial begin
    test_reset();
    test_add_seq();
    test_vectors();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_mp_seq.md
ALU_MP_SEQ -- requirements
Module: alu_mp_seq

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, width of one ALU slice in bits.
REQ-002 SHALL have parameter OPCODE_WIDTH, default 3, ALU opcode width.
REQ-003 SHALL have parameter WORDS, default 4, slices per operand; operand width W = DATA_WIDTH*WORDS.
REQ-004 SHALL have one clock and an asynchronous, active-low reset: clk  input  1  rising-edge clock.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 req_valid  input  1  request offered.
REQ-007 req_ready  output  1  request accepted when high with req_valid at a rising edge.
REQ-008 req_op  input  OPCODE_WIDTH  operation code.
REQ-009 req_a, req_b  input  W  operands A, B.
REQ-010 req_cin  input  1  carry-in, used by ADDF only.
REQ-011 rsp_valid  output  1  result available.
REQ-012 rsp_ready  input  1  result consumed when high with rsp_valid at a rising edge.
REQ-013 rsp_data  output  W  result; rsp_carry  output  1  final carry.
REQ-014 alu_i_1, alu_i_2  output  DATA_WIDTH  operands to the external combinational ALU.
REQ-015 alu_op_code  output  OPCODE_WIDTH; alu_carry_in  output  1  to the ALU.
REQ-016 alu_o_main  input  DATA_WIDTH; alu_carry_out  input  1  from the ALU, same cycle.

Function
REQ-017 Opcode encoding SHALL be ADD=0, ADDF=1, SUBTRACT=2, AND_OP=3, OR_OP=4, XOR_OP=5, NOT_OP=6, LOAD=7; any unlisted value SHALL be treated as LOAD.
REQ-018 FSM SHALL have states IDLE, EXEC, DONE; req_ready=1 only in IDLE, rsp_valid=1 only in DONE.
REQ-019 IDLE: on req_valid SHALL latch req_op, req_a, req_b, req_cin, clear slice index k and carry register, go to EXEC.
REQ-020 EXEC: each cycle SHALL drive slice k (bits k*DATA_WIDTH upward, slice 0 least significant) to the ALU and capture alu_o_main into result slice k at the next edge.
REQ-021 EXEC: when k=WORDS-1 the next state SHALL be DONE; otherwise k increments; latency from accept edge to rsp_valid high is exactly WORDS cycles.
REQ-022 ADD: slice 0 SHALL issue ADD with alu_carry_in=0; slices 1..WORDS-1 SHALL issue ADDF with alu_carry_in = registered alu_carry_out of previous slice.
REQ-023 ADDF: as ADD but every slice issues ADDF and slice 0 uses the latched req_cin.
REQ-024 SUBTRACT: every slice SHALL issue ADDF with alu_i_2 = ~B slice; slice 0 alu_carry_in=1; rsp_carry=1 means no borrow (A>=B unsigned).
REQ-025 AND_OP, OR_OP, XOR_OP, NOT_OP, LOAD: every slice SHALL issue the same opcode with alu_carry_in=0; rsp_carry SHALL be 0.
REQ-026 For arithmetic ops rsp_carry SHALL equal alu_carry_out captured from slice WORDS-1.
REQ-027 Outside EXEC, alu_i_1, alu_i_2, alu_op_code, alu_carry_in SHALL be 0.
REQ-028 DONE: rsp_data and rsp_carry SHALL hold stable until rsp_ready; on rsp_ready go to IDLE.
REQ-029 req_valid during EXEC or DONE SHALL be ignored; rsp_ready outside DONE SHALL be ignored.
REQ-030 rsp_ready in DONE together with req_valid SHALL return to IDLE only; the new request is accepted no earlier than the following edge.
REQ-031 Operands SHALL be taken only from latched copies; req_a/req_b changes after accept SHALL not affect the result.

Reset
REQ-032 rst_n low SHALL immediately force IDLE, k=0, carry register 0, rsp_data=0, rsp_carry=0, rsp_valid=0, ALU outputs 0; req_ready=1 after release.
REQ-033 Reset during EXEC or DONE SHALL abort the operation with no response.

Verification
REQ-034 ADD A=0x00FFFFFF, B=0x00000001 -> rsp_data=0x01000000, rsp_carry=0, rsp_valid exactly 4 cycles after accept; alu_op_code sequence 0,1,1,1.
REQ-035 ADD 0xFFFFFFFF+0x00000001 -> 0x00000000 carry 1; ADDF 0x00000000+0x00000000 cin=1 -> 0x00000001 carry 0.
REQ-036 SUBTRACT 0x00000100-0x00000001 -> 0x000000FF carry 1; 0x00000000-0x00000001 -> 0xFFFFFFFF carry 0.
REQ-037 XOR 0xF0F0F0F0,0xFFFF0000 -> 0x0F0FF0F0; NOT A=0x12345678 -> 0xEDCBA987; LOAD B=0xCAFEBABE -> 0xCAFEBABE; all carry 0.
REQ-038 rsp_ready held low 5 cycles in DONE -> rsp_data stable, req_ready=0, second req_valid ignored; accepted only after DONE->IDLE.
REQ-039 rst_n pulsed low in 2nd EXEC cycle -> outputs zero immediately, no rsp_valid, next request completes correctly.
